line_pingpong_buffer: RTL and testbench

Parametrised single-clock ping-pong line buffer between the ADC capture front end and the frame output path of the thermal imager. Accepts NCH ADC samples per beat, assembles complete rows of PIX_IN_ROW pixels into one of two banks, and streams finished rows out one pixel per cycle with valid/ready flow control. If both banks are busy when a new row starts, that row is dropped and counted; the buffer never overwrites a row that has not been read.

---
 rtl/line_pingpong_buffer_pkg.sv | 36 +++
 rtl/line_bank_ram.sv | 42 ++++
 rtl/line_pingpong_buffer.sv | 186 ++++++++++++++++++
 tb/tb_line_pingpong_buffer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pingpong_buffer_pkg.sv
// line_pingpong_buffer_pkg
//   Shared defaults and types for the ping-pong line buffer.
//   - Default sample width, row length and channel count (overridable macros).
//   - pix_tag_t: sideband that travels alongside a pixel through the read
//     pipeline (valid, start-of-line, end-of-line).
//   - lane_shift(): log2 of the channel count, used to turn a pixel index
//     into a RAM word index.

`ifndef ADC_WIDHT
`define ADC_WIDHT 14
`endif

`ifndef PIX_IN_ROW
`define PIX_IN_ROW 160
`endif

`ifndef LPB_NCH
`define LPB_NCH 2
`endif

package line_pingpong_buffer_pkg;

  typedef struct packed {
    logic valid;
    logic sol;
    logic eol;
  } pix_tag_t;

  // Channel count is restricted to 1, 2 or 4, so a shift replaces division.
  function automatic int lane_shift(input int nch);
    if (nch >= 4) return 2;
    else if (nch == 2) return 1;
    else return 0;
  endfunction

endpackage

// File: rtl/line_bank_ram.sv
// line_bank_ram
//   Simple dual-port, single-clock RAM holding both row banks.
//   Word = NCH samples; bank select is the address MSB.
//   Read is synchronous and only updates when rd_en is high, so the read
//   register holds its pixel while the downstream pipeline is stalled.
// Ports:
//   clk                      clock
//   wr_en/wr_addr/wr_data    write port (one full beat per word)
//   rd_en/rd_addr/rd_lane    read request; lane picks the sample in the word
//   rd_pixel                 selected sample, valid the cycle after rd_en

module line_bank_ram #(
  parameter int DATA_W = 14,
  parameter int NCH    = 2,
  parameter int AW     = 3,
  parameter int LW     = 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [NCH*DATA_W-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  input  logic [LW-1:0]         rd_lane,
  output logic [DATA_W-1:0]     rd_pixel
);

  logic [NCH*DATA_W-1:0] mem [0:(2**AW)-1];
  logic [NCH*DATA_W-1:0] rd_word;
  logic [LW-1:0]         rd_lane_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) begin
      rd_word   <= mem[rd_addr];
      rd_lane_q <= rd_lane;
    end
  end

  assign rd_pixel = rd_word[int'(rd_lane_q) * DATA_W +: DATA_W];

endmodule

// File: rtl/line_pingpong_buffer.sv
// line_pingpong_buffer
//   Two-bank line buffer: assembles rows of PIX_IN_ROW pixels arriving NCH per
//   beat, then streams each finished row out one pixel per cycle.
//   A row that starts while its target bank still holds an unread row is
//   consumed but not stored, and counted in DROP_CNT.
// Ports:
//   CLK, RESET                clock, async active-low reset
//   IN_VALID/IN_DATA/IN_SOL   input beats (lane 0 = lowest pixel index)
//   OUT_VALID/OUT_READY       output handshake
//   OUT_DATA/OUT_SOL/OUT_EOL  pixel and row markers
//   ROW_DONE                  one-cycle pulse when a row is committed
//   DROP_CNT                  dropped rows, saturating at 255
//   BUF_FULL                  both banks hold unread rows
//
// Handshake: a pixel transfers on a rising edge where OUT_VALID && OUT_READY.
// While OUT_VALID is high and OUT_READY low, OUT_DATA/OUT_SOL/OUT_EOL hold.
// IN_VALID has no back-pressure: every valid beat is consumed.

module line_pingpong_buffer
  import line_pingpong_buffer_pkg::*;
#(
  parameter int DATA_W     = `ADC_WIDHT,
  parameter int PIX_IN_ROW = `PIX_IN_ROW,
  parameter int NCH        = `LPB_NCH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  input  logic [NCH*DATA_W-1:0] IN_DATA,
  input  logic                  IN_SOL,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_W-1:0]     OUT_DATA,
  output logic                  OUT_SOL,
  output logic                  OUT_EOL,
  output logic                  ROW_DONE,
  output logic [7:0]            DROP_CNT,
  output logic                  BUF_FULL
);

  localparam int WORDS = PIX_IN_ROW / NCH;
  localparam int IW    = $clog2(WORDS);
  localparam int AW    = IW + 1;
  localparam int CW    = $clog2(PIX_IN_ROW + 1);
  localparam int LW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LG    = lane_shift(NCH);

  localparam logic [CW-1:0] STEP      = CW'(NCH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(PIX_IN_ROW - NCH);
  localparam logic [CW-1:0] LAST_PIX  = CW'(PIX_IN_ROW - 1);
  localparam logic [CW-1:0] LANE_MASK = CW'(NCH - 1);

  // Bank state
  logic [1:0]    full, full_nxt;
  logic          wsel, rsel;

  // Write side
  logic [CW-1:0] wr_cnt, eff_cnt;
  logic          dropping;
  logic          row_start, row_end, drop_beat, wr_en, commit;
  logic [AW-1:0] wr_addr;

  // Read side: isel/icnt is the issue pointer into the RAM. It runs up to two
  // pixels ahead of the output register; rsel tracks the bank whose pixels are
  // currently leaving, and that bank is released on its last transfer.
  logic          isel;
  logic [CW-1:0] icnt;
  logic          advance, issue, row_release;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] rd_lane;
  logic [DATA_W-1:0] ram_pixel;
  pix_tag_t      s1, s1_nxt;

  // ---------------- write side ----------------
  always_comb begin
    eff_cnt   = IN_SOL ? '0 : wr_cnt;
    row_start = IN_VALID && (eff_cnt == '0);
    row_end   = IN_VALID && (eff_cnt == LAST_BEAT);
    // The drop decision for a new row uses the registered full flag, so a
    // bank released on this same edge is still treated as busy.
    drop_beat = row_start ? full[wsel] : dropping;
    wr_en     = IN_VALID && !drop_beat;
    commit    = row_end && !drop_beat;
    wr_addr   = {wsel, IW'(eff_cnt >> LG)};
  end

  always_comb begin
    full_nxt = full;
    if (row_release) full_nxt[rsel] = 1'b0;
    if (commit)      full_nxt[wsel] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      full     <= 2'b00;
      wsel     <= 1'b0;
      wr_cnt   <= '0;
      dropping <= 1'b0;
      ROW_DONE <= 1'b0;
      DROP_CNT <= 8'd0;
    end else begin
      full     <= full_nxt;
      ROW_DONE <= commit;
      if (IN_VALID) begin
        wr_cnt <= row_end ? '0 : eff_cnt + STEP;
        if (row_start) dropping <= full[wsel];
        if (row_end) begin
          if (drop_beat) begin
            dropping <= 1'b0;
            if (DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
          end else begin
            wsel <= ~wsel;
          end
        end
      end
    end
  end

  assign BUF_FULL = full[0] & full[1];

  // ---------------- read side ----------------
  // Both pipeline stages (RAM read register and output register) move
  // together, only when the output register is empty or being emptied.
  always_comb begin
    advance     = !OUT_VALID || OUT_READY;
    issue       = advance && full[isel];
    row_release = OUT_VALID && OUT_READY && OUT_EOL;
    rd_addr     = {isel, IW'(icnt >> LG)};
    rd_lane     = LW'(icnt & LANE_MASK);
    s1_nxt      = '0;
    if (issue) begin
      s1_nxt.valid = 1'b1;
      s1_nxt.sol   = (icnt == '0);
      s1_nxt.eol   = (icnt == LAST_PIX);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      isel      <= 1'b0;
      icnt      <= '0;
      rsel      <= 1'b0;
      s1        <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_SOL   <= 1'b0;
      OUT_EOL   <= 1'b0;
    end else begin
      if (issue) begin
        if (icnt == LAST_PIX) begin
          icnt <= '0;
          isel <= ~isel;
        end else begin
          icnt <= icnt + CW'(1);
        end
      end
      if (advance) begin
        s1        <= s1_nxt;
        OUT_VALID <= s1.valid;
        if (s1.valid) begin
          OUT_DATA <= ram_pixel;
          OUT_SOL  <= s1.sol;
          OUT_EOL  <= s1.eol;
        end
      end
      if (row_release) rsel <= ~rsel;
    end
  end

  line_bank_ram #(
    .DATA_W (DATA_W),
    .NCH    (NCH),
    .AW     (AW),
    .LW     (LW)
  ) u_ram (
    .clk      (CLK),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (IN_DATA),
    .rd_en    (issue),
    .rd_addr  (rd_addr),
    .rd_lane  (rd_lane),
    .rd_pixel (ram_pixel)
  );

endmodule

// File: tb/tb_line_pingpong_buffer.sv
// tb_line_pingpong_buffer
//   Bench for line_pingpong_buffer with DATA_W=14, PIX_IN_ROW=8, NCH=2.
//   Model: a row is stored when fewer than two stored rows are still unread
//   at the moment its first beat is sampled; stored rows come out in order.

module tb_line_pingpong_buffer;

  localparam int DATA_W = 14;
  localparam int PIX    = 8;
  localparam int NCH    = 2;
  localparam int BEATS  = PIX / NCH;
  localparam int WW     = DATA_W + 2;   // {sol, eol, data}

  // ---------------- clock / reset ----------------
  logic                  CLK = 1'b0;
  logic                  RESET = 1'b1;
  logic                  IN_VALID = 1'b0;
  logic [NCH*DATA_W-1:0] IN_DATA = '0;
  logic                  IN_SOL = 1'b0;
  logic                  OUT_VALID;
  logic                  OUT_READY = 1'b0;
  logic [DATA_W-1:0]     OUT_DATA;
  logic                  OUT_SOL;
  logic                  OUT_EOL;
  logic                  ROW_DONE;
  logic [7:0]            DROP_CNT;
  logic                  BUF_FULL;

  always #5 CLK = ~CLK;

  line_pingpong_buffer #(
    .DATA_W     (DATA_W),
    .PIX_IN_ROW (PIX),
    .NCH        (NCH)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_DATA   (IN_DATA),
    .IN_SOL    (IN_SOL),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_SOL   (OUT_SOL),
    .OUT_EOL   (OUT_EOL),
    .ROW_DONE  (ROW_DONE),
    .DROP_CNT  (DROP_CNT),
    .BUF_FULL  (BUF_FULL)
  );

  // ---------------- scoreboard state ----------------
  logic [WW-1:0]     exp_q[$];
  logic [DATA_W-1:0] row_pix [PIX];
  int n_vec = 0;
  int n_err = 0;
  int committed = 0;   // rows the model expects to be stored
  int released = 0;    // stored rows fully consumed
  int done_seen = 0;   // ROW_DONE pulses observed
  int drop_exp = 0;    // expected DROP_CNT
  int ready_mode = 1;  // 0 hold low, 1 hold high, 2 pattern 1,0,0, 3 random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      IN_SOL   = 1'b0;
      IN_DATA  = NCH*DATA_W'($urandom);
    end
  endtask

  task automatic drive_beat(input int b, input bit sol);
    IN_VALID = 1'b1;
    IN_SOL   = sol;
    for (int k = 0; k < NCH; k++) IN_DATA[k*DATA_W +: DATA_W] = row_pix[b*NCH + k];
  endtask

  task automatic fill_random();
    for (int p = 0; p < PIX; p++) row_pix[p] = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
  endtask

  // Full row with IN_SOL on its first beat; model decides store vs drop.
  task automatic send_row();
    bit drop = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      @(posedge CLK); #1;
      if (b == 0) drop = ((committed - released) >= 2);
      drive_beat(b, b == 0);
    end
    if (!drop) begin
      committed++;
      for (int p = 0; p < PIX; p++)
        exp_q.push_back({(p == 0) ? 1'b1 : 1'b0, (p == PIX - 1) ? 1'b1 : 1'b0, row_pix[p]});
    end else if (drop_exp < 255) begin
      drop_exp++;
    end
  endtask

  // Incomplete row, abandoned by the next IN_SOL.
  task automatic send_partial(input int n);
    fill_random();
    for (int b = 0; b < n; b++) begin
      @(posedge CLK); #1;
      drive_beat(b, b == 0);
    end
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      @(negedge CLK);
      t++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge CLK);
  endtask

  // ---------------- consumer ready ----------------
  initial begin : ready_gen
    int ph = 0;
    forever begin
      @(posedge CLK); #1;
      case (ready_mode)
        0:       OUT_READY = 1'b0;
        1:       OUT_READY = 1'b1;
        2:       begin OUT_READY = ((ph % 3) == 0); ph++; end
        default: OUT_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [WW-1:0] held_word;
    logic [WW-1:0] w;
    bit stalled = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        exp_q.delete();
        released  = 0;
        done_seen = 0;
        stalled   = 1'b0;
        continue;
      end
      if (ROW_DONE) done_seen++;
      if (stalled) begin
        check("stall_valid_held", 32'(OUT_VALID), 32'd1);
        check("stall_pixel_held", 32'({OUT_SOL, OUT_EOL, OUT_DATA}), 32'(held_word));
      end
      if (OUT_VALID && OUT_READY) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pixel: got 0x%0h with no pixel expected at %0t",
                   {OUT_SOL, OUT_EOL, OUT_DATA}, $time);
        end else begin
          w = exp_q.pop_front();
          check("pixel", 32'({OUT_SOL, OUT_EOL, OUT_DATA}), 32'(w));
          if (w[DATA_W]) released++;
        end
      end else if (OUT_VALID) begin
        stalled   = 1'b1;
        held_word = {OUT_SOL, OUT_EOL, OUT_DATA};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 32'(OUT_VALID), 32'd0);
    check({tag, "_out_data"},  32'(OUT_DATA),  32'd0);
    check({tag, "_out_sol"},   32'(OUT_SOL),   32'd0);
    check({tag, "_out_eol"},   32'(OUT_EOL),   32'd0);
    check({tag, "_row_done"},  32'(ROW_DONE),  32'd0);
    check({tag, "_drop_cnt"},  32'(DROP_CNT),  32'd0);
    check({tag, "_buf_full"},  32'(BUF_FULL),  32'd0);
  endtask

  initial begin : main
    int t;
    ready_mode = 1;
    #1 RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    @(posedge CLK); #1;
    RESET = 1'b1;

    // Directed row 0..7: ROW_DONE after last beat, first pixel two cycles later.
    for (int p = 0; p < PIX; p++) row_pix[p] = DATA_W'(p);
    send_row();
    drive_idle(1);
    @(negedge CLK);
    check("lat_row_done", 32'(ROW_DONE), 32'd1);
    check("lat_valid_n", 32'(OUT_VALID), 32'd0);
    @(negedge CLK);
    check("lat_valid_n1", 32'(OUT_VALID), 32'd0);
    check("lat_row_done_pulse", 32'(ROW_DONE), 32'd0);
    @(negedge CLK);
    check("lat_valid_n2", 32'(OUT_VALID), 32'd1);
    check("lat_first_pixel", 32'({OUT_SOL, OUT_DATA}), 32'({1'b1, DATA_W'(0)}));
    wait_drain(50);
    check("row_done_count_1", 32'(done_seen), 32'(committed));

    // Stalling consumer 1,0,0,1,...
    ready_mode = 2;
    fill_random();
    send_row();
    drive_idle(1);
    wait_drain(100);

    // Three back-to-back rows with no consumer: third is dropped.
    ready_mode = 0;
    drive_idle(2);
    for (int r = 0; r < 3; r++) begin
      fill_random();
      send_row();
    end
    drive_idle(4);
    check("abc_buf_full", 32'(BUF_FULL), 32'd1);
    check("abc_drop_cnt", 32'(DROP_CNT), 32'(drop_exp));
    ready_mode = 1;
    wait_drain(100);
    check("abc_buf_empty", 32'(BUF_FULL), 32'd0);

    // Partial row abandoned by a new IN_SOL.
    send_partial(2);
    fill_random();
    send_row();
    drive_idle(1);
    wait_drain(50);
    check("partial_row_done_count", 32'(done_seen), 32'(committed));

    // Randomized rows, gaps, partials and back-pressure.
    ready_mode = 3;
    for (int r = 0; r < 14; r++) begin
      drive_idle($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) send_partial($urandom_range(1, BEATS - 1));
      fill_random();
      send_row();
    end
    drive_idle(1);
    ready_mode = 1;
    wait_drain(400);
    check("rand_row_done_count", 32'(done_seen), 32'(committed));
    check("rand_drop_cnt", 32'(DROP_CNT), 32'(drop_exp));

    // Drop counter saturation.
    ready_mode = 0;
    drive_idle(2);
    for (int r = 0; r < 302; r++) begin
      fill_random();
      send_row();
    end
    drive_idle(3);
    check("sat_drop_cnt_model", 32'(DROP_CNT), 32'(drop_exp));
    check("sat_drop_cnt_255", 32'(DROP_CNT), 32'd255);
    check("sat_buf_full", 32'(BUF_FULL), 32'd1);
    ready_mode = 1;
    wait_drain(100);

    // Reset in the middle of streaming a row.
    fill_random();
    send_row();
    drive_idle(1);
    t = 0;
    while (!OUT_VALID && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check("mid_reset_streaming", 32'(OUT_VALID), 32'd1);
    repeat (2) @(negedge CLK);
    @(posedge CLK); #2;
    RESET = 1'b0;
    committed = 0;
    drop_exp  = 0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    drive_idle(2);
    fill_random();
    send_row();
    drive_idle(1);
    wait_drain(50);
    check("post_reset_row_done_count", 32'(done_seen), 32'(committed));
    check("post_reset_drop_cnt", 32'(DROP_CNT), 32'(drop_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
